// File: rtl/rs_int_age.sv
// rs_int_age: two-wide integer reservation station. Holds renamed instructions
// until both operands are valid, snoops NCDB result buses (with same-cycle
// bypass into dispatching slots) and issues the two oldest ready entries per
// cycle through registered valid/ready issue ports.
module rs_int_age #(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 32,
    parameter  int TAG_W  = 5,
    parameter  int NCDB   = 4,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int SEQ_W  = $clog2(DEPTH) + 1,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    // dispatch slot 1
    input  logic                   d1_valid,
    input  logic [4:0]             d1_op,
    input  logic [4:0]             d1_dst,
    input  logic [4:0]             d1_shamt,
    input  logic [TAG_W-1:0]       d1_dst_tag,
    input  logic [TAG_W-1:0]       d1_tag1,
    input  logic [TAG_W-1:0]       d1_tag2,
    input  logic                   d1_v1,
    input  logic                   d1_v2,
    input  logic [DATA_W-1:0]      d1_val1,
    input  logic [DATA_W-1:0]      d1_val2,
    input  logic [DATA_W-1:0]      d1_imm,
    // dispatch slot 2
    input  logic                   d2_valid,
    input  logic [4:0]             d2_op,
    input  logic [4:0]             d2_dst,
    input  logic [4:0]             d2_shamt,
    input  logic [TAG_W-1:0]       d2_dst_tag,
    input  logic [TAG_W-1:0]       d2_tag1,
    input  logic [TAG_W-1:0]       d2_tag2,
    input  logic                   d2_v1,
    input  logic                   d2_v2,
    input  logic [DATA_W-1:0]      d2_val1,
    input  logic [DATA_W-1:0]      d2_val2,
    input  logic [DATA_W-1:0]      d2_imm,
    // result buses
    input  logic [NCDB-1:0]        cdb_we,
    input  logic [NCDB*TAG_W-1:0]  cdb_tag,
    input  logic [NCDB*DATA_W-1:0] cdb_val,
    // issue port 1
    output logic                   i1_valid,
    input  logic                   i1_ready,
    output logic [4:0]             i1_op,
    output logic [4:0]             i1_dst,
    output logic [4:0]             i1_shamt,
    output logic [TAG_W-1:0]       i1_dst_tag,
    output logic [DATA_W-1:0]      i1_imm,
    output logic [DATA_W-1:0]      i1_val1,
    output logic [DATA_W-1:0]      i1_val2,
    output logic                   i1_we,
    // issue port 2
    output logic                   i2_valid,
    input  logic                   i2_ready,
    output logic [4:0]             i2_op,
    output logic [4:0]             i2_dst,
    output logic [4:0]             i2_shamt,
    output logic [TAG_W-1:0]       i2_dst_tag,
    output logic [DATA_W-1:0]      i2_imm,
    output logic [DATA_W-1:0]      i2_val1,
    output logic [DATA_W-1:0]      i2_val2,
    output logic                   i2_we,
    // occupancy
    output logic                   full,
    output logic [CNT_W-1:0]       free_cnt
);

    // Returns {hit, value}; buses are scanned high to low so the lowest k wins.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]       tag,
        input logic [NCDB-1:0]        we,
        input logic [NCDB*TAG_W-1:0]  tags,
        input logic [NCDB*DATA_W-1:0] vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int k = NCDB - 1; k >= 0; k--) begin
            if (we[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, vals[k*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    // Wrap-safe age compare: a is older than b when (a - b) is negative.
    function automatic logic is_older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] d;
        d = a - b;
        return d[SEQ_W-1];
    endfunction

    // entry state
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  v1_q;
    logic [DEPTH-1:0]  v2_q;
    logic [TAG_W-1:0]  tag1_q    [DEPTH];
    logic [TAG_W-1:0]  tag2_q    [DEPTH];
    logic [DATA_W-1:0] val1_q    [DEPTH];
    logic [DATA_W-1:0] val2_q    [DEPTH];
    logic [DATA_W-1:0] imm_q     [DEPTH];
    logic [4:0]        op_q      [DEPTH];
    logic [4:0]        dst_q     [DEPTH];
    logic [4:0]        shamt_q   [DEPTH];
    logic [TAG_W-1:0]  dtag_q    [DEPTH];
    logic [SEQ_W-1:0]  seq_q     [DEPTH];
    logic [SEQ_W-1:0]  seq_ctr;

    // snoop results per entry operand
    logic [DEPTH-1:0]  snp1_hit;
    logic [DEPTH-1:0]  snp2_hit;
    logic [DATA_W-1:0] snp1_val  [DEPTH];
    logic [DATA_W-1:0] snp2_val  [DEPTH];

    // dispatch-side bypass
    logic              b11_hit, b12_hit, b21_hit, b22_hit;
    logic [DATA_W-1:0] b11_val, b12_val, b21_val, b22_val;
    logic              d1_v2_eff, d2_v2_eff;
    logic              d1_v1_w, d1_v2_w, d2_v1_w, d2_v2_w;
    logic [DATA_W-1:0] d1_val1_w, d1_val2_w, d2_val1_w, d2_val2_w;

    // allocation / select
    logic              w1, w2;
    logic [IDX_W-1:0]  f0_idx, f1_idx, a1_idx, a2_idx;
    logic              f0_ok, f1_ok;
    logic              first_ok, second_ok;
    logic [IDX_W-1:0]  first_idx, second_idx;
    logic              ld1, ld2;
    logic              sel1_ok, sel2_ok;
    logic [IDX_W-1:0]  sel1_idx, sel2_idx;
    logic [DEPTH-1:0]  busy_nxt;

    // Snoop every entry operand against all result buses.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {snp1_hit[i], snp1_val[i]} = cdb_lookup(tag1_q[i], cdb_we, cdb_tag, cdb_val);
            {snp2_hit[i], snp2_val[i]} = cdb_lookup(tag2_q[i], cdb_we, cdb_tag, cdb_val);
        end
    end

    assign {b11_hit, b11_val} = cdb_lookup(d1_tag1, cdb_we, cdb_tag, cdb_val);
    assign {b12_hit, b12_val} = cdb_lookup(d1_tag2, cdb_we, cdb_tag, cdb_val);
    assign {b21_hit, b21_val} = cdb_lookup(d2_tag1, cdb_we, cdb_tag, cdb_val);
    assign {b22_hit, b22_val} = cdb_lookup(d2_tag2, cdb_we, cdb_tag, cdb_val);

    // Immediate forms (op[1]=1) never wait on source 2.
    assign d1_v2_eff = d1_v2 | d1_op[1];
    assign d2_v2_eff = d2_v2 | d2_op[1];
    assign d1_v1_w   = d1_v1 | b11_hit;
    assign d1_v2_w   = d1_v2_eff | b12_hit;
    assign d2_v1_w   = d2_v1 | b21_hit;
    assign d2_v2_w   = d2_v2_eff | b22_hit;
    assign d1_val1_w = (!d1_v1 && b11_hit) ? b11_val : d1_val1;
    assign d1_val2_w = (!d1_v2_eff && b12_hit) ? b12_val : d1_val2;
    assign d2_val1_w = (!d2_v1 && b21_hit) ? b21_val : d2_val1;
    assign d2_val2_w = (!d2_v2_eff && b22_hit) ? b22_val : d2_val2;

    // Occupancy from registered busy bits.
    always_comb begin
        free_cnt = CNT_W'(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            free_cnt = free_cnt - CNT_W'(busy_q[i]);
        end
    end

    assign full = (free_cnt < CNT_W'(2));
    assign w1   = d1_valid && !full && !flush && (d1_dst != 5'd0);
    assign w2   = d2_valid && !full && !flush && (d2_dst != 5'd0);

    // Find the two lowest-index free entries.
    always_comb begin
        f0_ok  = 1'b0;
        f1_ok  = 1'b0;
        f0_idx = '0;
        f1_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy_q[i]) begin
                if (!f0_ok) begin
                    f0_ok  = 1'b1;
                    f0_idx = IDX_W'(i);
                end else if (!f1_ok) begin
                    f1_ok  = 1'b1;
                    f1_idx = IDX_W'(i);
                end
            end
        end
    end

    assign a1_idx = f0_idx;
    assign a2_idx = w1 ? f1_idx : f0_idx;

    // Rank ready entries by age; rank 0 is the oldest, rank 1 the next.
    always_comb begin
        logic [DEPTH-1:0] cand;
        logic [CNT_W-1:0] rank;
        first_ok   = 1'b0;
        second_ok  = 1'b0;
        first_idx  = '0;
        second_idx = '0;
        cand       = busy_q & v1_q & v2_q;
        for (int i = 0; i < DEPTH; i++) begin
            rank = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && cand[j] && is_older(seq_q[j], seq_q[i])) begin
                    rank = rank + CNT_W'(1);
                end
            end
            if (cand[i] && rank == CNT_W'(0)) begin
                first_ok  = 1'b1;
                first_idx = IDX_W'(i);
            end
            if (cand[i] && rank == CNT_W'(1)) begin
                second_ok  = 1'b1;
                second_idx = IDX_W'(i);
            end
        end
    end

    // Oldest goes to the lower-numbered loadable port, second-oldest to the other.
    assign ld1      = !i1_valid || i1_ready;
    assign ld2      = !i2_valid || i2_ready;
    assign sel1_ok  = ld1 && first_ok;
    assign sel1_idx = first_idx;
    assign sel2_ok  = ld2 && (ld1 ? second_ok : first_ok);
    assign sel2_idx = ld1 ? second_idx : first_idx;

    // Next busy vector: selected entries leave, dispatched entries arrive.
    always_comb begin
        busy_nxt = busy_q;
        if (sel1_ok) busy_nxt[sel1_idx] = 1'b0;
        if (sel2_ok) busy_nxt[sel2_idx] = 1'b0;
        if (w1)      busy_nxt[a1_idx]   = 1'b1;
        if (w2)      busy_nxt[a2_idx]   = 1'b1;
    end

    // Control state: busy bits, age counter and issue-port valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= '0;
            seq_ctr  <= '0;
            i1_valid <= 1'b0;
            i2_valid <= 1'b0;
        end else if (flush) begin
            busy_q   <= '0;
            i1_valid <= 1'b0;
            i2_valid <= 1'b0;
        end else begin
            busy_q  <= busy_nxt;
            seq_ctr <= seq_ctr + SEQ_W'(w1) + SEQ_W'(w2);
            if (ld1) i1_valid <= sel1_ok;
            if (ld2) i2_valid <= sel2_ok;
        end
    end

    // Entry payload: snoop capture into waiting operands plus dispatch writes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && !v1_q[i] && snp1_hit[i]) begin
                v1_q[i]   <= 1'b1;
                val1_q[i] <= snp1_val[i];
            end
            if (busy_q[i] && !v2_q[i] && snp2_hit[i]) begin
                v2_q[i]   <= 1'b1;
                val2_q[i] <= snp2_val[i];
            end
        end
        if (w1) begin
            v1_q[a1_idx]    <= d1_v1_w;
            v2_q[a1_idx]    <= d1_v2_w;
            tag1_q[a1_idx]  <= d1_tag1;
            tag2_q[a1_idx]  <= d1_tag2;
            val1_q[a1_idx]  <= d1_val1_w;
            val2_q[a1_idx]  <= d1_val2_w;
            imm_q[a1_idx]   <= d1_imm;
            op_q[a1_idx]    <= d1_op;
            dst_q[a1_idx]   <= d1_dst;
            shamt_q[a1_idx] <= d1_shamt;
            dtag_q[a1_idx]  <= d1_dst_tag;
            seq_q[a1_idx]   <= seq_ctr;
        end
        if (w2) begin
            v1_q[a2_idx]    <= d2_v1_w;
            v2_q[a2_idx]    <= d2_v2_w;
            tag1_q[a2_idx]  <= d2_tag1;
            tag2_q[a2_idx]  <= d2_tag2;
            val1_q[a2_idx]  <= d2_val1_w;
            val2_q[a2_idx]  <= d2_val2_w;
            imm_q[a2_idx]   <= d2_imm;
            op_q[a2_idx]    <= d2_op;
            dst_q[a2_idx]   <= d2_dst;
            shamt_q[a2_idx] <= d2_shamt;
            dtag_q[a2_idx]  <= d2_dst_tag;
            seq_q[a2_idx]   <= w1 ? seq_ctr + SEQ_W'(1) : seq_ctr;
        end
    end

    // Issue-register payload: loaded only when the port takes a new entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            i1_op      <= '0;
            i1_dst     <= '0;
            i1_shamt   <= '0;
            i1_dst_tag <= '0;
            i1_imm     <= '0;
            i1_val1    <= '0;
            i1_val2    <= '0;
            i2_op      <= '0;
            i2_dst     <= '0;
            i2_shamt   <= '0;
            i2_dst_tag <= '0;
            i2_imm     <= '0;
            i2_val1    <= '0;
            i2_val2    <= '0;
        end else if (!flush) begin
            if (sel1_ok) begin
                i1_op      <= op_q[sel1_idx];
                i1_dst     <= dst_q[sel1_idx];
                i1_shamt   <= shamt_q[sel1_idx];
                i1_dst_tag <= dtag_q[sel1_idx];
                i1_imm     <= imm_q[sel1_idx];
                i1_val1    <= val1_q[sel1_idx];
                i1_val2    <= val2_q[sel1_idx];
            end
            if (sel2_ok) begin
                i2_op      <= op_q[sel2_idx];
                i2_dst     <= dst_q[sel2_idx];
                i2_shamt   <= shamt_q[sel2_idx];
                i2_dst_tag <= dtag_q[sel2_idx];
                i2_imm     <= imm_q[sel2_idx];
                i2_val1    <= val1_q[sel2_idx];
                i2_val2    <= val2_q[sel2_idx];
            end
        end
    end

    assign i1_we = (i1_dst != 5'd0);
    assign i2_we = (i2_dst != 5'd0);

endmodule

// File: tb/tb_rs_int_age.sv
// Directed bench for rs_int_age: reset, issue latency, bypass, full/fill and
// age-ordered drain, issue-port stall, flush and dst=0 discard.
module tb_rs_int_age;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int NCDB   = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset, flush;
    logic d1_valid, d1_v1, d1_v2, d2_valid, d2_v1, d2_v2;
    logic [4:0] d1_op, d1_dst, d1_shamt, d2_op, d2_dst, d2_shamt;
    logic [TAG_W-1:0] d1_dst_tag, d1_tag1, d1_tag2, d2_dst_tag, d2_tag1, d2_tag2;
    logic [DATA_W-1:0] d1_val1, d1_val2, d1_imm, d2_val1, d2_val2, d2_imm;
    logic [NCDB-1:0] cdb_we;
    logic [NCDB*TAG_W-1:0] cdb_tag;
    logic [NCDB*DATA_W-1:0] cdb_val;
    logic i1_valid, i1_ready, i1_we, i2_valid, i2_ready, i2_we;
    logic [4:0] i1_op, i1_dst, i1_shamt, i2_op, i2_dst, i2_shamt;
    logic [TAG_W-1:0] i1_dst_tag, i2_dst_tag;
    logic [DATA_W-1:0] i1_imm, i1_val1, i1_val2, i2_imm, i2_val1, i2_val2;
    logic full;
    logic [CNT_W-1:0] free_cnt;

    rs_int_age #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .NCDB(NCDB)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .d1_valid(d1_valid), .d1_op(d1_op), .d1_dst(d1_dst), .d1_shamt(d1_shamt),
        .d1_dst_tag(d1_dst_tag), .d1_tag1(d1_tag1), .d1_tag2(d1_tag2),
        .d1_v1(d1_v1), .d1_v2(d1_v2), .d1_val1(d1_val1), .d1_val2(d1_val2), .d1_imm(d1_imm),
        .d2_valid(d2_valid), .d2_op(d2_op), .d2_dst(d2_dst), .d2_shamt(d2_shamt),
        .d2_dst_tag(d2_dst_tag), .d2_tag1(d2_tag1), .d2_tag2(d2_tag2),
        .d2_v1(d2_v1), .d2_v2(d2_v2), .d2_val1(d2_val1), .d2_val2(d2_val2), .d2_imm(d2_imm),
        .cdb_we(cdb_we), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .i1_valid(i1_valid), .i1_ready(i1_ready), .i1_op(i1_op), .i1_dst(i1_dst),
        .i1_shamt(i1_shamt), .i1_dst_tag(i1_dst_tag), .i1_imm(i1_imm),
        .i1_val1(i1_val1), .i1_val2(i1_val2), .i1_we(i1_we),
        .i2_valid(i2_valid), .i2_ready(i2_ready), .i2_op(i2_op), .i2_dst(i2_dst),
        .i2_shamt(i2_shamt), .i2_dst_tag(i2_dst_tag), .i2_imm(i2_imm),
        .i2_val1(i2_val1), .i2_val2(i2_val2), .i2_we(i2_we),
        .full(full), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0;
        d1_valid = 1'b0; d1_op = '0; d1_dst = '0; d1_shamt = '0; d1_dst_tag = '0;
        d1_tag1 = '0; d1_tag2 = '0; d1_v1 = 1'b0; d1_v2 = 1'b0;
        d1_val1 = '0; d1_val2 = '0; d1_imm = '0;
        d2_valid = 1'b0; d2_op = '0; d2_dst = '0; d2_shamt = '0; d2_dst_tag = '0;
        d2_tag1 = '0; d2_tag2 = '0; d2_v1 = 1'b0; d2_v2 = 1'b0;
        d2_val1 = '0; d2_val2 = '0; d2_imm = '0;
        cdb_we = '0; cdb_tag = '0; cdb_val = '0;
    endtask

    task automatic set_d1(input logic [4:0] op, input logic [4:0] dst, input logic [4:0] dtag,
                          input logic [4:0] t1, input logic v1, input logic [31:0] val1,
                          input logic [4:0] t2, input logic v2, input logic [31:0] val2,
                          input logic [31:0] imm);
        d1_valid = 1'b1; d1_op = op; d1_dst = dst; d1_dst_tag = dtag; d1_shamt = imm[4:0];
        d1_tag1 = t1; d1_v1 = v1; d1_val1 = val1;
        d1_tag2 = t2; d1_v2 = v2; d1_val2 = val2; d1_imm = imm;
    endtask

    task automatic set_d2(input logic [4:0] op, input logic [4:0] dst, input logic [4:0] dtag,
                          input logic [4:0] t1, input logic v1, input logic [31:0] val1,
                          input logic [4:0] t2, input logic v2, input logic [31:0] val2,
                          input logic [31:0] imm);
        d2_valid = 1'b1; d2_op = op; d2_dst = dst; d2_dst_tag = dtag; d2_shamt = imm[4:0];
        d2_tag1 = t1; d2_v1 = v1; d2_val1 = val1;
        d2_tag2 = t2; d2_v2 = v2; d2_val2 = val2; d2_imm = imm;
    endtask

    initial begin
        idle();
        reset = 1'b1; i1_ready = 1'b1; i2_ready = 1'b1;
        tick(); tick();
        chk("rst_i1_valid", i1_valid, 0);
        chk("rst_i2_valid", i2_valid, 0);
        chk("rst_free_cnt", free_cnt, DEPTH);
        chk("rst_full", full, 0);
        chk("rst_i1_val1", i1_val1, 0);
        chk("rst_i2_dst_tag", i2_dst_tag, 0);
        reset = 1'b0;

        // two ready ADDs
        set_d1(5'd0, 5'd1, 5'd3, 5'd0, 1'b1, 32'd10, 5'd0, 1'b1, 32'd20, 32'h103);
        set_d2(5'd0, 5'd2, 5'd4, 5'd0, 1'b1, 32'd5, 5'd0, 1'b1, 32'd6, 32'h204);
        tick(); idle();
        chk("t1_free_after_disp", free_cnt, DEPTH - 2);
        chk("t1_i1_not_yet", i1_valid, 0);
        tick();
        chk("t1_i1_valid", i1_valid, 1);
        chk("t1_i1_dst_tag", i1_dst_tag, 3);
        chk("t1_i2_valid", i2_valid, 1);
        chk("t1_i2_dst_tag", i2_dst_tag, 4);
        chk("t1_i1_val1", i1_val1, 10);
        chk("t1_i2_val2", i2_val2, 6);
        chk("t1_i1_shamt", i1_shamt, 3);
        chk("t1_i1_imm", i1_imm, 32'h103);
        chk("t1_i1_we", i1_we, 1);
        chk("t1_free_back", free_cnt, DEPTH);
        tick();
        chk("t1_i1_drained", i1_valid, 0);
        chk("t1_i2_drained", i2_valid, 0);

        // bypass on bus 2; bus 3 carries the same tag and must lose
        set_d1(5'd0, 5'd3, 5'd10, 5'd7, 1'b0, 32'd0, 5'd0, 1'b1, 32'd1, 32'd0);
        cdb_we = 4'b1100;
        cdb_tag[2*TAG_W +: TAG_W] = 5'd7;  cdb_val[2*DATA_W +: DATA_W] = 32'h1234;
        cdb_tag[3*TAG_W +: TAG_W] = 5'd7;  cdb_val[3*DATA_W +: DATA_W] = 32'h9999;
        tick(); idle();
        chk("t2_free", free_cnt, DEPTH - 1);
        chk("t2_i1_not_yet", i1_valid, 0);
        tick();
        chk("t2_i1_valid", i1_valid, 1);
        chk("t2_i1_val1", i1_val1, 32'h1234);
        chk("t2_i1_dst_tag", i1_dst_tag, 10);
        chk("t2_i2_valid", i2_valid, 0);
        tick();
        chk("t2_i1_drained", i1_valid, 0);

        // fill DEPTH-1 entries waiting on tag 9
        for (int n = 0; n < DEPTH - 1; n += 2) begin
            set_d1(5'd0, 5'(n + 1), 5'(20 + n), 5'd9, 1'b0, 32'd0, 5'd0, 1'b1, 32'(n), 32'd0);
            if (n + 1 < DEPTH - 1)
                set_d2(5'd0, 5'(n + 2), 5'(21 + n), 5'd9, 1'b0, 32'd0, 5'd0, 1'b1, 32'(n + 1), 32'd0);
            tick(); idle();
        end
        chk("t3_free_one", free_cnt, 1);
        chk("t3_full", full, 1);
        set_d1(5'd0, 5'd1, 5'd31, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0);
        set_d2(5'd0, 5'd2, 5'd30, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0);
        tick(); idle();
        chk("t3_full_ignored", free_cnt, 1);
        chk("t3_nothing_ready", i1_valid, 0);
        cdb_we = 4'b0001;
        cdb_tag[0 +: TAG_W] = 5'd9; cdb_val[0 +: DATA_W] = 32'h55;
        tick(); idle();
        chk("t3_snoop_no_same_cycle", i1_valid, 0);
        for (int p = 0; p < 4; p++) begin
            tick();
            chk("t3_i1_valid", i1_valid, 1);
            chk("t3_i1_order", i1_dst_tag, 32'(20 + 2 * p));
            chk("t3_i1_val1", i1_val1, 32'h55);
            if (p < 3) begin
                chk("t3_i2_valid", i2_valid, 1);
                chk("t3_i2_order", i2_dst_tag, 32'(21 + 2 * p));
            end else begin
                chk("t3_i2_empty", i2_valid, 0);
            end
            chk("t3_free_drain", free_cnt, (p < 3) ? 32'(3 + 2 * p) : 32'(DEPTH));
        end
        tick();
        chk("t3_i1_done", i1_valid, 0);
        chk("t3_i2_done", i2_valid, 0);

        // stall port 1
        i1_ready = 1'b0;
        set_d1(5'd0, 5'd1, 5'd11, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0);
        set_d2(5'd0, 5'd2, 5'd12, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0);
        tick();
        set_d1(5'd0, 5'd3, 5'd13, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0);
        set_d2(5'd0, 5'd4, 5'd14, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0);
        tick(); idle();
        chk("t4_i1_a", i1_dst_tag, 11);
        chk("t4_i2_b", i2_dst_tag, 12);
        chk("t4_free_wait", free_cnt, DEPTH - 2);
        tick();
        chk("t4_i1_hold", i1_dst_tag, 11);
        chk("t4_i2_c", i2_dst_tag, 13);
        chk("t4_free_c", free_cnt, DEPTH - 1);
        tick();
        chk("t4_i1_hold2", i1_dst_tag, 11);
        chk("t4_i2_d", i2_dst_tag, 14);
        tick();
        chk("t4_i1_still_valid", i1_valid, 1);
        chk("t4_i2_empty", i2_valid, 0);

        // flush while stalled with busy entries
        set_d1(5'd0, 5'd1, 5'd16, 5'd30, 1'b0, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0);
        set_d2(5'd0, 5'd2, 5'd17, 5'd30, 1'b0, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0);
        tick(); idle();
        chk("t5_free_pre", free_cnt, DEPTH - 2);
        flush = 1'b1;
        set_d1(5'd0, 5'd1, 5'd18, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0);
        cdb_we = 4'b0001; cdb_tag[0 +: TAG_W] = 5'd30;
        tick(); idle();
        chk("t5_i1_flushed", i1_valid, 0);
        chk("t5_i2_flushed", i2_valid, 0);
        chk("t5_free_flushed", free_cnt, DEPTH);
        chk("t5_not_full", full, 0);
        i1_ready = 1'b1;
        cdb_we = 4'b0001; cdb_tag[0 +: TAG_W] = 5'd30;
        tick(); idle();
        tick();
        chk("t5_no_ghost", i1_valid, 0);

        // dst=0 discarded; slot 2 immediate form takes the lowest entry
        set_d1(5'd0, 5'd0, 5'd19, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0);
        set_d2(5'd2, 5'd5, 5'd15, 5'd0, 1'b1, 32'd7, 5'd28, 1'b0, 32'd0, 32'h44);
        tick(); idle();
        chk("t6_free_one_alloc", free_cnt, DEPTH - 1);
        tick();
        chk("t6_i1_valid", i1_valid, 1);
        chk("t6_i1_dst_tag", i1_dst_tag, 15);
        chk("t6_i1_op", i1_op, 2);
        chk("t6_i1_imm", i1_imm, 32'h44);
        chk("t6_i2_empty", i2_valid, 0);
        set_d1(5'd0, 5'd0, 5'd19, 5'd0, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 32'd0);
        tick(); idle();
        chk("t6_dst0_free", free_cnt, DEPTH);
        tick();
        chk("t6_dst0_no_issue", i1_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
